reg_xfer_ctrl: RTL and testbench

Register-transfer sequencer for the CPU datapath's internal register file (A, X, Y, SP, ...). It accepts one transfer request at a time (source index, destination index) on a valid/ready handshake. It reads the source register by strobing its output enable and capturing its data into a holding latch, then writes that value into the destination register with a one-hot load strobe. It is the reading and driving counterpart to the per-register load/output-enable storage elements, and it implements the TAX/TXA/TSX/TXS-style moves.

---
 rtl/reg_xfer_ctrl.sv | 175 +++++++++++++++++
 tb/tb_reg_xfer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: register-transfer sequencer for the CPU register file.
// It accepts one (src, dst) request per transfer on a valid/ready handshake.
// It reads the source by strobing oe[src] and captures the value in a holding
// latch. It then writes the latch into the destination with a one-hot ld strobe.
// Sequence: IDLE -> READ -> WRITE -> IDLE, one transfer per three cycles.
// Optional build macro XFER_FLAGS_EN adds registered N/Z flag outputs
// (flag_n, flag_z) derived from the captured value.
module reg_xfer_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int SELW  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SELW-1:0]         req_src,
    input  logic [SELW-1:0]         req_dst,
    input  logic [NREG*WIDTH-1:0]   rd_data,
    output logic [NREG-1:0]         oe,
    output logic [NREG-1:0]         ld,
    output logic [WIDTH-1:0]        ld_data,
    output logic                    done,
    output logic                    err
`ifdef XFER_FLAGS_EN
    ,
    output logic                    flag_n,
    output logic                    flag_z
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // NREG widened by one bit so an all-ones index still compares correctly
    localparam logic [SELW:0] NREG_W = (SELW+1)'(NREG);

    // True when the index addresses an attached register
    function automatic logic idx_legal(input logic [SELW-1:0] idx);
        return ({1'b0, idx} < NREG_W);
    endfunction

    // One-hot decode of a register index
    function automatic logic [NREG-1:0] one_hot(input logic [SELW-1:0] idx);
        logic [NREG-1:0] vec;
        for (int i = 0; i < NREG; i++) begin
            if (idx == SELW'(i)) vec[i] = 1'b1;
            else                 vec[i] = 1'b0;
        end
        return vec;
    endfunction

    // Select one register's data word from the packed read bus
    function automatic logic [WIDTH-1:0] select_reg(input logic [NREG*WIDTH-1:0] bus,
                                                    input logic [SELW-1:0]       idx);
        logic [WIDTH-1:0] val;
        val = {WIDTH{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            if (idx == SELW'(i)) val = bus[i*WIDTH +: WIDTH];
            else                 val = val;
        end
        return val;
    endfunction

    state_t            state_r,  state_nxt_s;
    logic [SELW-1:0]   src_r,    src_nxt_s;
    logic [SELW-1:0]   dst_r,    dst_nxt_s;
    logic [NREG-1:0]   oe_r,     oe_nxt_s;
    logic [NREG-1:0]   ld_r,     ld_nxt_s;
    logic              done_r,   done_nxt_s;
    logic              err_r,    err_nxt_s;
    logic [WIDTH-1:0]  latch_r,  latch_nxt_s;
    logic [WIDTH-1:0]  capture_s;
`ifdef XFER_FLAGS_EN
    logic              flag_n_r, flag_n_nxt_s;
    logic              flag_z_r, flag_z_nxt_s;
`endif

    assign capture_s = select_reg(rd_data, src_r);

    // Next-state and next-output decode; every registered output is computed here
    always_comb begin
        state_nxt_s = state_r;
        src_nxt_s   = src_r;
        dst_nxt_s   = dst_r;
        oe_nxt_s    = {NREG{1'b0}};
        ld_nxt_s    = {NREG{1'b0}};
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        latch_nxt_s = latch_r;
`ifdef XFER_FLAGS_EN
        flag_n_nxt_s = flag_n_r;
        flag_z_nxt_s = flag_z_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    src_nxt_s = req_src;
                    dst_nxt_s = req_dst;
                    if (idx_legal(req_src) && idx_legal(req_dst)) begin
                        state_nxt_s = ST_READ;
                        oe_nxt_s    = one_hot(req_src);
                    end else begin
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // Source is driving rd_data this cycle; capture and queue the load
                latch_nxt_s = capture_s;
                ld_nxt_s    = one_hot(dst_r);
                done_nxt_s  = 1'b1;
                state_nxt_s = ST_WRITE;
`ifdef XFER_FLAGS_EN
                flag_n_nxt_s = capture_s[WIDTH-1];
                flag_z_nxt_s = (capture_s == {WIDTH{1'b0}});
`endif
            end
            ST_WRITE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            src_r    <= {SELW{1'b0}};
            dst_r    <= {SELW{1'b0}};
            oe_r     <= {NREG{1'b0}};
            ld_r     <= {NREG{1'b0}};
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            latch_r  <= {WIDTH{1'b0}};
`ifdef XFER_FLAGS_EN
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            src_r    <= src_nxt_s;
            dst_r    <= dst_nxt_s;
            oe_r     <= oe_nxt_s;
            ld_r     <= ld_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            latch_r  <= latch_nxt_s;
`ifdef XFER_FLAGS_EN
            flag_n_r <= flag_n_nxt_s;
            flag_z_r <= flag_z_nxt_s;
`endif
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign oe        = oe_r;
    assign ld        = ld_r;
    assign ld_data   = latch_r;
    assign done      = done_r;
    assign err       = err_r;
`ifdef XFER_FLAGS_EN
    assign flag_n    = flag_n_r;
    assign flag_z    = flag_z_r;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: a four-register instance for the main
// sequence and a three-register instance for illegal-index requests.
module tb_reg_xfer_ctrl;

    typedef struct {
        logic [3:0] ld_exp;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_src, req_dst;
    logic [31:0] rd_data;
    logic [3:0]  oe, ld;
    logic [7:0]  ld_data;
    logic        done, err;

    logic        req_valid3, req_ready3;
    logic [1:0]  req_src3, req_dst3;
    logic [23:0] rd_data3;
    logic [2:0]  oe3, ld3;
    logic [7:0]  ld_data3;
    logic        done3, err3;
`ifdef XFER_FLAGS_EN
    logic        flag_n, flag_z, flag_n3, flag_z3;
`endif

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    reg_xfer_ctrl #(.WIDTH(8), .NREG(4), .SELW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .rd_data(rd_data), .oe(oe), .ld(ld),
        .ld_data(ld_data), .done(done), .err(err)
`ifdef XFER_FLAGS_EN
        , .flag_n(flag_n), .flag_z(flag_z)
`endif
    );

    reg_xfer_ctrl #(.WIDTH(8), .NREG(3), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_src(req_src3), .req_dst(req_dst3), .rd_data(rd_data3), .oe(oe3), .ld(ld3),
        .ld_data(ld_data3), .done(done3), .err(err3)
`ifdef XFER_FLAGS_EN
        , .flag_n(flag_n3), .flag_z(flag_z3)
`endif
    );

    function automatic logic [7:0] reg_val(input logic [1:0] idx);
        return rd_data[idx*8 +: 8];
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_src = 2'd0; req_dst = 2'd0;
        req_valid3 = 1'b0; req_src3 = 2'd0; req_dst3 = 2'd0;
        rd_data = {8'h7F, 8'h00, 8'h5A, 8'hA5};
        rd_data3 = {8'h3C, 8'h96, 8'h11};
        step(); step();
        rst_n = 1'b1;
        step();
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
        total++; if (oe !== 4'b0000) $display("FAIL reset_oe: got %b want 0000", oe); else passed++;
        total++; if (ld !== 4'b0000) $display("FAIL reset_ld: got %b want 0000", ld); else passed++;
        total++; if (ld_data !== 8'h00) $display("FAIL reset_ld_data: got %h want 00", ld_data); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
`ifdef XFER_FLAGS_EN
        total++; if ({flag_n, flag_z} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {flag_n, flag_z}); else passed++;
`endif
    endtask

    task automatic test_basic();
        total++; if (req_ready !== 1'b1) $display("FAIL basic_ready_T: got %b want 1", req_ready); else passed++;
        req_valid = 1'b1; req_src = 2'd0; req_dst = 2'd1;
        sb.push_back('{ld_exp: 4'b0010, data: reg_val(2'd0)});
        step();
        // fields need not stay stable after acceptance
        req_valid = 1'b0; req_src = 2'd3; req_dst = 2'd3;
        total++; if (oe !== 4'b0001) $display("FAIL basic_oe_T1: got %b want 0001", oe); else passed++;
        total++; if ({ld, done, err, req_ready} !== 7'b0) $display("FAIL basic_idle_T1: got %b want 0", {ld, done, err, req_ready}); else passed++;
        step();
        e = sb.pop_front();
        total++; if (ld !== e.ld_exp) $display("FAIL basic_ld_T2: got %b want %b", ld, e.ld_exp); else passed++;
        total++; if (ld_data !== e.data) $display("FAIL basic_ld_data_T2: got %h want %h", ld_data, e.data); else passed++;
        total++; if (done !== 1'b1) $display("FAIL basic_done_T2: got %b want 1", done); else passed++;
        total++; if (oe !== 4'b0000) $display("FAIL basic_oe_T2: got %b want 0000", oe); else passed++;
        step();
        total++; if (req_ready !== 1'b1) $display("FAIL basic_ready_T3: got %b want 1", req_ready); else passed++;
        total++; if ({oe, ld, done} !== 9'b0) $display("FAIL basic_quiet_T3: got %b want 0", {oe, ld, done}); else passed++;
        total++; if (ld_data !== 8'hA5) $display("FAIL basic_hold_T3: got %h want a5", ld_data); else passed++;
    endtask

    task automatic test_back_to_back();
        int last = -100;
        int nacc = 0;
        req_valid = 1'b1; req_src = 2'd2; req_dst = 2'd3;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; $display("FAIL b2b_spurious_done: got done=1 want no pending transfer");
                end else begin
                    e = sb.pop_front();
                    total++; if (ld !== e.ld_exp) $display("FAIL b2b_ld: got %b want %b", ld, e.ld_exp); else passed++;
                    total++; if (ld_data !== e.data) $display("FAIL b2b_ld_data: got %h want %h", ld_data, e.data); else passed++;
                end
            end
            total++; if ((oe & ld) !== 4'b0000) $display("FAIL b2b_overlap: got oe=%b ld=%b want disjoint", oe, ld); else passed++;
            if (c == last + 1) begin
                req_src = (req_src == 2'd2) ? 2'd3 : 2'd2;
                req_dst = (req_dst == 2'd3) ? 2'd2 : 2'd3;
            end
            if (req_ready === 1'b1) begin
                if (last >= 0) begin
                    total++; if (c - last != 3) $display("FAIL b2b_spacing: got %0d want 3", c - last); else passed++;
                end
                last = c;
                nacc++;
                sb.push_back('{ld_exp: 4'b0001 << req_dst, data: reg_val(req_src)});
            end
            step();
        end
        req_valid = 1'b0;
        total++; if (nacc != 4) $display("FAIL b2b_accepts: got %0d want 4", nacc); else passed++;
        total++; if (sb.size() != 0) $display("FAIL b2b_pending: got %0d want 0", sb.size()); else passed++;
        sb.delete();
    endtask

    task automatic test_err();
        req_valid3 = 1'b1; req_src3 = 2'd3; req_dst3 = 2'd0;
        step();
        total++; if (err3 !== 1'b1) $display("FAIL err_src_pulse: got %b want 1", err3); else passed++;
        total++; if ({oe3, ld3, done3} !== 7'b0) $display("FAIL err_src_quiet: got %b want 0", {oe3, ld3, done3}); else passed++;
        total++; if (req_ready3 !== 1'b1) $display("FAIL err_ready_T1: got %b want 1", req_ready3); else passed++;
        req_src3 = 2'd0; req_dst3 = 2'd3;
        step();
        total++; if (err3 !== 1'b1) $display("FAIL err_dst_pulse: got %b want 1", err3); else passed++;
        total++; if (ld_data3 !== 8'h00) $display("FAIL err_latch_kept: got %h want 00", ld_data3); else passed++;
        req_src3 = 2'd1; req_dst3 = 2'd2;
        sb.push_back('{ld_exp: 4'b0100, data: 8'h96});
        step();
        req_valid3 = 1'b0;
        total++; if (err3 !== 1'b0) $display("FAIL err_legal_clear: got %b want 0", err3); else passed++;
        total++; if (oe3 !== 3'b010) $display("FAIL err_next_oe: got %b want 010", oe3); else passed++;
        step();
        e = sb.pop_front();
        total++; if ({1'b0, ld3} !== e.ld_exp) $display("FAIL err_next_ld: got %b want %b", ld3, e.ld_exp[2:0]); else passed++;
        total++; if (ld_data3 !== e.data) $display("FAIL err_next_data: got %h want %h", ld_data3, e.data); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd0;
        step();
        req_valid = 1'b0;
        total++; if (oe !== 4'b0010) $display("FAIL rstmid_oe_read: got %b want 0010", oe); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (oe !== 4'b0000) $display("FAIL rstmid_oe_async: got %b want 0000", oe); else passed++;
        total++; if (ld_data !== 8'h00) $display("FAIL rstmid_latch_async: got %h want 00", ld_data); else passed++;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if ({ld, done} !== 5'b0) $display("FAIL rstmid_no_ld: got %b want 0", {ld, done}); else passed++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({ld, done} !== 5'b0) $display("FAIL rstmid_no_ld_after: got %b want 0", {ld, done}); else passed++;
        end
        total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", req_ready); else passed++;
        total++; if (ld_data !== 8'h00) $display("FAIL rstmid_ld_data: got %h want 00", ld_data); else passed++;
    endtask

`ifdef XFER_FLAGS_EN
    task automatic test_flags();
        rd_data[15:8] = 8'h80;
        req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd0;
        step();
        req_valid = 1'b0;
        step();
        total++; if ({flag_n, flag_z} !== 2'b10) $display("FAIL flags_neg: got %b want 10", {flag_n, flag_z}); else passed++;
        step();
        req_valid = 1'b1; req_src = 2'd2; req_dst = 2'd0;
        step();
        req_valid = 1'b0;
        step();
        total++; if ({flag_n, flag_z} !== 2'b01) $display("FAIL flags_zero: got %b want 01", {flag_n, flag_z}); else passed++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_err();
        test_reset_mid();
`ifdef XFER_FLAGS_EN
        test_flags();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
